// File: rtl/leaf_stream_arbiter_if.sv
// Stream bundle between NUM_REQ operator outputs, the arbiter and one leaf_interface input port.
// master = requesters plus leaf_interface side, slave = the arbiter.
interface leaf_stream_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req;
    logic [NUM_REQ-1:0]              vld_req;
    logic [NUM_REQ-1:0]              ack_req;
    logic [PAYLOAD_BITS-1:0]         dout;
    logic                            vld_out;
    logic                            ack_out;
    logic [GW-1:0]                   grant_id;
    logic                            busy;

    modport master (
        output din_req, vld_req, ack_out,
        input  ack_req, dout, vld_out, grant_id, busy
    );

    modport slave (
        input  din_req, vld_req, ack_out,
        output ack_req, dout, vld_out, grant_id, busy
    );
endinterface

// File: rtl/leaf_stream_arbiter.sv
// Round-robin arbiter merging NUM_REQ vld/ack streams into one registered output slot.
// Optional macro LEAF_ARB_BURST_LOCK_EN holds each grant for up to MAX_BURST words.
module leaf_stream_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int MAX_BURST    = 8
) (
    input logic                  clk,
    input logic                  reset_n,
    leaf_stream_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    // Handshake: a word moves on any cycle with vld && ack high; data is held while vld && !ack.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [GW-1:0]           r_grant;
    logic [GW-1:0]           w_grant_nxt;
    logic [GW-1:0]           r_rr_ptr;
    logic [GW-1:0]           w_ptr_nxt;
    logic [GW-1:0]           w_next_ptr;
    logic [CW-1:0]           r_burst_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [PAYLOAD_BITS-1:0] r_dout;
    logic                    r_vld_out;

    logic                    w_busy;
    logic                    w_slot_free;
    logic                    w_vld_g;
    logic [PAYLOAD_BITS-1:0] w_word;
    logic                    w_xfer;
    logic                    w_stall_rel;
    logic                    w_last;
    logic                    w_release;

    // First requesting index scanning upward from ptr with wrap.
    function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] ptr,
                                              input logic [NUM_REQ-1:0] req);
        int unsigned k;
        rr_pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (req[k]) rr_pick = GW'(k);
        end
    endfunction

    always_comb begin
        w_vld_g = 1'b0;
        w_word  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GW'(i)) begin
                w_vld_g = bus.vld_req[i];
                w_word  = bus.din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign w_busy      = (r_state == S_GRANT);
    assign w_slot_free = !r_vld_out || bus.ack_out;
    assign w_xfer      = w_busy && w_vld_g && w_slot_free;
    assign w_stall_rel = w_busy && w_slot_free && !w_vld_g;
    assign w_next_ptr  = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

`ifdef LEAF_ARB_BURST_LOCK_EN
    assign w_last = (r_burst_cnt == CW'(MAX_BURST - 1));
`else
    assign w_last = 1'b1;
`endif

    assign w_release = (w_xfer && w_last) || w_stall_rel;

    always_comb begin
        bus.ack_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.ack_req[i] = w_xfer && (r_grant == GW'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_rr_ptr;
        w_cnt_nxt   = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (|bus.vld_req) begin
                    w_grant_nxt = rr_pick(r_rr_ptr, bus.vld_req);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // Re-arbitrate in the release cycle so back-to-back grants cost no bubble.
                if (w_release) begin
                    w_ptr_nxt = w_next_ptr;
                    w_cnt_nxt = '0;
                    if (|bus.vld_req) begin
                        w_grant_nxt = rr_pick(w_next_ptr, bus.vld_req);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_xfer) begin
                    w_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_dout      <= '0;
            r_vld_out   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_burst_cnt <= w_cnt_nxt;
            if (w_xfer) begin
                r_dout    <= w_word;
                r_vld_out <= 1'b1;
            end else if (w_slot_free) begin
                r_vld_out <= 1'b0;
            end
        end
    end

    assign bus.dout     = r_dout;
    assign bus.vld_out  = r_vld_out;
    assign bus.grant_id = r_grant;
    assign bus.busy     = w_busy;
endmodule

// File: tb/tb_leaf_stream_arbiter.sv
// Randomized bench for leaf_stream_arbiter against a transaction-level round-robin model.
module tb_leaf_stream_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    leaf_stream_arbiter_if #(.NUM_REQ(N), .PAYLOAD_BITS(W)) bus ();

    leaf_stream_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(W), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [W-1:0] exp_q[$];
    bit           m_busy;
    int           m_g;
    int           m_ptr;
    int           m_words;
    logic [W-1:0] m_dout;

    logic [W-1:0] req_data[N];
    logic [N-1:0] req_vld;
    logic [N-1:0] last_ack;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy   = 1'b0;
        m_g      = 0;
        m_ptr    = 0;
        m_words  = 0;
        m_dout   = '0;
        last_ack = '0;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) bus.din_req[i*W +: W] = req_data[i];
        bus.vld_req = req_vld;
    endtask

    function automatic int rr_winner(input int start, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Compare one cycle at the falling edge, then advance the model across the rising edge.
    task automatic step();
        logic [N-1:0] v;
        logic [N-1:0] e_ack;
        bit           slot_free;
        bit           xfer;
        bit           rel;
        int           win;
        @(negedge clk);
        v         = bus.vld_req;
        slot_free = (exp_q.size() == 0) || bus.ack_out;
        e_ack     = '0;
        if (m_busy && v[m_g] && slot_free) e_ack[m_g] = 1'b1;
        xfer = (e_ack != 0);
        check_val("ack_req", bus.ack_req, e_ack);
        check_val("grant_id", bus.grant_id, m_g);
        check_val("busy", bus.busy, m_busy);
        check_val("vld_out", bus.vld_out, exp_q.size() != 0);
        check_val("dout", bus.dout, (exp_q.size() != 0) ? exp_q[0] : m_dout);
        last_ack = bus.ack_req;

        if (exp_q.size() != 0 && bus.ack_out) void'(exp_q.pop_front());
        if (xfer) begin
            exp_q.push_back(req_data[m_g]);
            m_dout = req_data[m_g];
        end

        if (m_busy) begin
            rel = 1'b0;
            if (xfer) begin
                m_words++;
`ifdef LEAF_ARB_BURST_LOCK_EN
                rel = (m_words == MB);
`else
                rel = 1'b1;
`endif
            end else if (slot_free && !v[m_g]) begin
                rel = 1'b1;
            end
            if (rel) begin
                m_ptr   = (m_g + 1) % N;
                m_words = 0;
                win     = rr_winner(m_ptr, v);
                if (win < 0) m_busy = 1'b0;
                else m_g = win;
            end
        end else if (v != 0) begin
            m_g     = rr_winner(m_ptr, v);
            m_busy  = 1'b1;
            m_words = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Requesters keep data stable while valid and not yet accepted.
    task automatic drive_random(input int p_vld, input int p_ack);
        for (int i = 0; i < N; i++) begin
            if (!(req_vld[i] && !last_ack[i])) begin
                req_vld[i]  = ($urandom_range(99) < p_vld);
                req_data[i] = $urandom;
            end
        end
        bus.ack_out = ($urandom_range(99) < p_ack);
        apply_inputs();
    endtask

    initial begin
        int k;
        req_vld = '0;
        for (int i = 0; i < N; i++) req_data[i] = '0;
        bus.ack_out = 1'b0;
        apply_inputs();
        model_reset();
        #22;
        check_val("rst_vld_out", bus.vld_out, 0);
        check_val("rst_dout", bus.dout, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_grant", bus.grant_id, 0);
        check_val("rst_ack_req", bus.ack_req, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single requester streaming 0x11..0x15.
        k = 0;
        bus.ack_out = 1'b1;
        req_vld     = 4'b0001;
        req_data[0] = 32'h11;
        apply_inputs();
        for (int c = 0; c < 12; c++) begin
            step();
            if (last_ack[0]) k++;
            req_vld[0]  = (k < 5);
            req_data[0] = 32'h11 + k;
            apply_inputs();
        end
        check_val("words_sent", k, 5);

        // All requesters busy, full-rate sink, then a 5-cycle backpressure window.
        for (int c = 0; c < 40; c++) begin
            drive_random(100, 100);
            step();
        end
        for (int c = 0; c < 5; c++) begin
            drive_random(100, 0);
            step();
        end
        for (int c = 0; c < 10; c++) begin
            drive_random(100, 100);
            step();
        end

        // Asynchronous reset mid-burst with a word in the slot.
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_vld_out", bus.vld_out, 0);
        check_val("arst_busy", bus.busy, 0);
        check_val("arst_ack_req", bus.ack_req, 0);
        check_val("arst_grant", bus.grant_id, 0);
        check_val("arst_dout", bus.dout, 0);
        model_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        req_vld = '1;
        apply_inputs();
        for (int c = 0; c < 20; c++) begin
            drive_random(100, 100);
            step();
        end

        // Mixed random traffic with sparse and dense requesters and a bursty sink.
        for (int c = 0; c < 3000; c++) begin
            drive_random((c / 500) % 2 ? 80 : 30, (c / 250) % 3 == 0 ? 40 : 90);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
